// File: rtl/pwm_pkg.sv
// Shared constants and the duty compare rule for the PWM peripheral.
package pwm_pkg;

   localparam int             PWM_CNT_W        = 8;
   localparam logic [7:0]     DUTY_FULL        = 8'hFF;
   localparam int             PWM_PRESCALE_DEF = 13;
   localparam int             NUM_OUT          = 16;

   // Full scale is a deliberate always-on rather than 255/256.
   function automatic logic pwm_compare(input logic [PWM_CNT_W-1:0] cnt,
                                        input logic [PWM_CNT_W-1:0] duty);
      return (duty == DUTY_FULL) || (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter; tick marks each count step, wrap marks 255->0.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int PRESCALE = PWM_PRESCALE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [PWM_CNT_W-1:0] cnt,
   output logic                 tick,
   output logic                 wrap
);

   localparam int             P_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [P_W-1:0] P_LAST = P_W'(PRESCALE - 1);

   logic [P_W-1:0] p;

   assign tick = (p == P_LAST);
   assign wrap = tick && (cnt == {PWM_CNT_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p   <= '0;
         cnt <= '0;
      end else begin
         if (tick) begin
            p   <= '0;
            cnt <= cnt + 1'b1;
         end else begin
            p   <= p + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 user outputs low / high / PWM from the SPI register file.
// Build option PWM_SHADOW_EN: duty is shadowed and only updated at the period wrap.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int PRESCALE = PWM_PRESCALE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         en_reg_out_7_0,
   input  logic [7:0]         en_reg_out_15_8,
   input  logic [7:0]         en_reg_pwm_7_0,
   input  logic [7:0]         en_reg_pwm_15_8,
   input  logic [7:0]         pwm_duty_cycle,
   output logic [NUM_OUT-1:0] out,
   output logic               period_start
);

   logic [NUM_OUT-1:0]   en_out;
   logic [NUM_OUT-1:0]   en_pwm;
   logic [PWM_CNT_W-1:0] cnt;
   logic [PWM_CNT_W-1:0] duty_act;
   logic                 tick;
   logic                 wrap;
   logic                 period_end;
   logic                 pwm_level;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_timebase #(
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt),
      .tick  (tick),
      .wrap  (wrap)
   );

   // wrap already implies tick; qualifying keeps the boundary tied to a count step.
   assign period_end = tick & wrap;

`ifdef PWM_SHADOW_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_act <= '0;
      end else if (period_end) begin
         duty_act <= pwm_duty_cycle;
      end
   end
`else
   assign duty_act = pwm_duty_cycle;
`endif

   assign pwm_level = pwm_compare(cnt, duty_act);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out          <= '0;
         period_start <= 1'b0;
      end else begin
         out          <= en_out & (~en_pwm | {NUM_OUT{pwm_level}});
         period_start <= period_end;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench: two instances (PRESCALE 13 and 1) compared every cycle against an edge-count model.
`timescale 1ns/1ps
module tb_pwm_peripheral;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] en_out_v;
   logic [15:0] en_pwm_v;
   logic [7:0]  duty;

   logic [15:0] out_w [2];
   logic        ps_w  [2];

   int checks   = 0;
   int failures = 0;
   int fail_prints = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gen_u
      localparam int P = (g == 0) ? 13 : 1;
      logic [15:0] out_d;
      logic        ps_d;

      pwm_peripheral #(.PRESCALE(P)) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .en_reg_out_7_0  (en_out_v[7:0]),
         .en_reg_out_15_8 (en_out_v[15:8]),
         .en_reg_pwm_7_0  (en_pwm_v[7:0]),
         .en_reg_pwm_15_8 (en_pwm_v[15:8]),
         .pwm_duty_cycle  (duty),
         .out             (out_d),
         .period_start    (ps_d)
      );

      assign out_w[g] = out_d;
      assign ps_w[g]  = ps_d;

      // Model: after k clock edges since reset release, the counter value is (k / P) % 256.
      int unsigned k;
      logic [15:0] exp_out;
      logic        exp_ps;
`ifdef PWM_SHADOW_EN
      logic [7:0]  duty_sh;
`endif

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            k       = 0;
            exp_out = '0;
            exp_ps  = 1'b0;
`ifdef PWM_SHADOW_EN
            duty_sh = '0;
`endif
         end else begin
            int unsigned c;
            logic [7:0]  d;
            logic        lvl;
            c = (k / P) % 256;
`ifdef PWM_SHADOW_EN
            d = duty_sh;
`else
            d = duty;
`endif
            lvl     = (d == 8'hFF) || (c < d);
            exp_out = en_out_v & (~en_pwm_v | {16{lvl}});
            k       = k + 1;
            exp_ps  = ((k % (256 * P)) == 0);
`ifdef PWM_SHADOW_EN
            if (exp_ps) duty_sh = duty;
`endif
         end
      end

      always @(negedge clk) begin
         checks++;
         if (out_d !== exp_out || ps_d !== exp_ps) begin
            failures++;
            if (fail_prints < 20) begin
               fail_prints++;
               $display("FAIL model_cmp u%0d t=%0t out=%h ps=%b expected out=%h ps=%b",
                        g, $time, out_d, ps_d, exp_out, exp_ps);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d (0x%h) expected=%0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_ps(input int g, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ps_w[g] && n < budget);
      if (!ps_w[g]) chk("period_start_timeout", n, budget + 1);
   endtask

   task automatic measure(input int g, input int len, input logic [15:0] pat,
                          input int chg_at, input logic [7:0] chg_duty,
                          output int hits, output logic [15:0] first);
      hits  = 0;
      first = '0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (i == 0) first = out_w[g];
         if (out_w[g] == pat) hits++;
         if (i == chg_at) duty = chg_duty;
      end
   endtask

   initial begin
      int          n;
      int          hits;
      logic [15:0] first;

      rst_n    = 1'b0;
      en_out_v = '0;
      en_pwm_v = '0;
      duty     = '0;
      repeat (3) @(negedge clk);
      chk("reset_out", out_w[0], 16'h0000);
      chk("reset_ps", ps_w[0], 0);
      rst_n = 1'b1;

      // static high
      en_out_v = 16'h0001;
      @(negedge clk);
      chk("static_bit0", out_w[0], 16'h0001);
      en_out_v = 16'h8000;
      @(negedge clk);
      chk("static_bit15", out_w[0], 16'h8000);

      // mixed select with duty 0
      en_out_v = 16'hFFFF;
      en_pwm_v = 16'h00F0;
      @(negedge clk);
      chk("mixed_static", out_w[0], 16'hFF0F);

      // 50% duty; out rises the cycle after period_start
      en_pwm_v = 16'hFFFF;
      duty     = 8'h80;
      wait_ps(0, 2 * 3328 + 4, n);
      chk("out_at_ps", out_w[0], 16'h0000);
      measure(0, 3328, 16'hFFFF, -1, 8'h00, hits, first);
      chk("duty50_high", hits, 1664);
      chk("duty50_first", first, 16'hFFFF);
      chk("ps_interval", ps_w[0], 1);

      // reset mid-period, inside the high phase
      repeat (100) @(negedge clk);
      chk("pre_reset_high", out_w[0], 16'hFFFF);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out", out_w[0], 16'h0000);
      chk("async_reset_ps", ps_w[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ps(0, 4000, n);
      chk("first_ps_after_reset", n, 3328);

      // duty extremes
      duty = 8'h00;
      wait_ps(0, 3400, n);
      measure(0, 2 * 3328, 16'h0000, -1, 8'h00, hits, first);
      chk("duty00_low", hits, 2 * 3328);
      duty = 8'hFF;
      wait_ps(0, 3400, n);
      measure(0, 2 * 3328, 16'hFFFF, -1, 8'h00, hits, first);
      chk("duty_ff_high", hits, 2 * 3328);

      // duty change 0x40 -> 0xC0 at count ~30 of a period
      duty = 8'h40;
      wait_ps(0, 3400, n);
      measure(0, 3328, 16'hFFFF, 400, 8'hC0, hits, first);
`ifdef PWM_SHADOW_EN
      chk("shadow_cur_period", hits, 832);
`else
      chk("direct_cur_period", hits, 2496);
`endif
      measure(0, 3328, 16'hFFFF, -1, 8'h00, hits, first);
      chk("duty_c0_next_period", hits, 2496);

      // PRESCALE=1 instance
      duty = 8'h03;
      wait_ps(1, 600, n);
      wait_ps(1, 300, n);
      chk("p1_ps_interval", n, 256);
      measure(1, 256, 16'hFFFF, -1, 8'h00, hits, first);
      chk("p1_duty3_high", hits, 3);
      chk("p1_first", first, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
